// File: rtl/arbitro_puerto_memoria.sv
// Round-robin arbiter sharing one 32-bit memory port among four requesters.
// Registered select/grant with hold-until-release, watchdog and one-cycle turnaround.
module arbitro_puerto_memoria #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam int unsigned LIM     = WD_EN ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LIM);

  state_t             state, state_n;
  logic [1:0]         sel_n, last, last_n, winner;
  logic [3:0]         grant_n;
  logic               busy_n, timeout_n, found;
  logic [CNT_W-1:0]   count, count_n;

  // Search starts just after the last owner; offset 4 wraps back onto it.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!found && req[2'(last + 2'(i))]) begin
        winner = 2'(last + 2'(i));
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    grant_n   = grant;
    busy_n    = busy;
    timeout_n = 1'b0;
    count_n   = count;
    last_n    = last;
    case (state)
      IDLE: begin
        grant_n = '0;
        busy_n  = 1'b0;
        if (found) begin
          state_n = GRANT;
          sel_n   = winner;
          grant_n = 4'b0001 << winner;
          busy_n  = 1'b1;
          count_n = '0;
        end
      end
      GRANT: begin
        if (done || !req[sel] || (WD_EN && count == CNT_LIM)) begin
          state_n   = IDLE;
          grant_n   = '0;
          busy_n    = 1'b0;
          last_n    = sel;
          // Only a watchdog release reaches here with done low and the owner still requesting.
          timeout_n = !done && req[sel];
        end else begin
          count_n = count + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      count   <= '0;
      last    <= 2'd3;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      grant   <= grant_n;
      busy    <= busy_n;
      timeout <= timeout_n;
      count   <= count_n;
      last    <= last_n;
    end
  end

endmodule

// File: tb/tb_arbitro_puerto_memoria.sv
// Directed bench for arbitro_puerto_memoria (TIMEOUT=4): stimulus pushes the
// hand-computed post-edge outputs into a queue, a monitor pops and compares them.
module tb_arbitro_puerto_memoria;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy, timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       to;
    string      name;
  } exp_t;

  exp_t q[$];

  arbitro_puerto_memoria #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic d, input logic [1:0] es, input logic [3:0] eg,
                      input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    reset = r;
    req   = rq;
    done  = d;
    e.sel = es; e.grant = eg; e.busy = eb; e.to = et; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        total++;
        if (sel !== e.sel || grant !== e.grant || busy !== e.busy || timeout !== e.to) begin
          bad++;
          $display("FAIL %s: got sel=%0d grant=%b busy=%b timeout=%b, want sel=%0d grant=%b busy=%b timeout=%b",
                   e.name, sel, grant, busy, timeout, e.sel, e.grant, e.busy, e.to);
        end
      end
    end
  end

  initial begin
    //    name          rst req      done sel   grant    busy to
    step("rst0",        1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0);
    step("rst1",        1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0);
    step("single_g",    0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("single_h1",   0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("single_h2",   0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("single_rel",  0, 4'b0100, 1, 2'd2, 4'b0000, 0, 0);
    step("idle_selhold",0, 4'b0000, 0, 2'd2, 4'b0000, 0, 0);
    // round robin starting after last=2
    step("rr_g3",       0, 4'b1111, 0, 2'd3, 4'b1000, 1, 0);
    step("rr_r3",       0, 4'b1111, 1, 2'd3, 4'b0000, 0, 0);
    step("rr_g0",       0, 4'b1111, 0, 2'd0, 4'b0001, 1, 0);
    step("rr_r0",       0, 4'b1111, 1, 2'd0, 4'b0000, 0, 0);
    step("rr_g1",       0, 4'b1111, 0, 2'd1, 4'b0010, 1, 0);
    step("rr_r1",       0, 4'b1111, 1, 2'd1, 4'b0000, 0, 0);
    step("rr_g2",       0, 4'b1111, 0, 2'd2, 4'b0100, 1, 0);
    step("rr_r2",       0, 4'b1111, 1, 2'd2, 4'b0000, 0, 0);
    step("rr_g3b",      0, 4'b1111, 0, 2'd3, 4'b1000, 1, 0);
    step("rr_r3b",      0, 4'b1111, 1, 2'd3, 4'b0000, 0, 0);
    // pointer skip / wrap
    step("ps_g1",       0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("ps_r1",       0, 4'b0010, 1, 2'd1, 4'b0000, 0, 0);
    step("ps_wrap0",    0, 4'b0001, 0, 2'd0, 4'b0001, 1, 0);
    step("ps_r0",       0, 4'b0001, 1, 2'd0, 4'b0000, 0, 0);
    step("ps_g3",       0, 4'b1000, 0, 2'd3, 4'b1000, 1, 0);
    step("ps_r3",       0, 4'b1000, 1, 2'd3, 4'b0000, 0, 0);
    step("ps_self3",    0, 4'b1000, 0, 2'd3, 4'b1000, 1, 0);
    step("ps_r3b",      0, 4'b1000, 1, 2'd3, 4'b0000, 0, 0);
    // watchdog: grant lasts exactly 4 cycles
    step("wd_g",        0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("wd_c1",       0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("wd_c2",       0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("wd_c3",       0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("wd_fire",     0, 4'b0010, 0, 2'd1, 4'b0000, 0, 1);
    step("wd_regrant",  0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    // done and timeout in the same cycle
    step("sim_c1",      0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("sim_c2",      0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("sim_c3",      0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("sim_done_wd", 0, 4'b0010, 1, 2'd1, 4'b0000, 0, 0);
    // watchdog with another requester pending, non-owner req changes ignored
    step("wd2_g",       0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("wd2_c1",      0, 4'b0011, 0, 2'd1, 4'b0010, 1, 0);
    step("wd2_c2",      0, 4'b0011, 0, 2'd1, 4'b0010, 1, 0);
    step("wd2_c3",      0, 4'b0011, 0, 2'd1, 4'b0010, 1, 0);
    step("wd2_fire",    0, 4'b0011, 0, 2'd1, 4'b0000, 0, 1);
    step("wd2_other",   0, 4'b0011, 0, 2'd0, 4'b0001, 1, 0);
    // owner drops request
    step("drop_abort",  0, 4'b0010, 0, 2'd0, 4'b0000, 0, 0);
    step("drop_g1",     0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("drop_abort2", 0, 4'b0000, 0, 2'd1, 4'b0000, 0, 0);
    step("idle_done",   0, 4'b0000, 1, 2'd1, 4'b0000, 0, 0);
    // reset mid-grant on the cycle the watchdog would fire
    step("rm_g2",       0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("rm_c1",       0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("rm_c2",       0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("rm_c3",       0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("rm_reset",    1, 4'b0100, 0, 2'd0, 4'b0000, 0, 0);
    step("rm_first0",   0, 4'b1111, 0, 2'd0, 4'b0001, 1, 0);
    step("rm_r0",       0, 4'b1111, 1, 2'd0, 4'b0000, 0, 0);
    step("rm_idle",     0, 4'b0000, 0, 2'd0, 4'b0000, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
